// File: rtl/spi_flash_responder_if.sv
// Byte-wide memory port between the SPI flash responder (master) and the backing store (slave).
interface spi_flash_responder_if #(
  parameter int ADDR_W = 24
);
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_rd_en;
  logic [7:0]        mem_rd_data;
  logic              mem_wr_en;
  logic [7:0]        mem_wr_data;
  logic              mem_erase_req;
  logic              mem_erase_done;

  modport master (
    output mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, mem_erase_req,
    input  mem_rd_data, mem_erase_done
  );

  modport slave (
    input  mem_addr, mem_rd_en, mem_wr_en, mem_wr_data, mem_erase_req,
    output mem_rd_data, mem_erase_done
  );
endinterface

// File: rtl/spi_flash_responder.sv
// SPI mode-0 target emulating a serial NOR flash over a byte-wide memory port.
// Program/erase support (0x06/0x04/0x02/0x20) is built only with SPI_FLASH_RESP_PROGRAM_EN.
module spi_flash_responder #(
  parameter int          ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016
) (
  input  logic                  clk_48mhz,
  input  logic                  reset,
  input  logic                  spi_sck,
  input  logic                  spi_cs,
  input  logic                  spi_mosi,
  output logic                  spi_miso,
  output logic                  spi_miso_oe,
  spi_flash_responder_if.master mem
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DUMMY, DOUT, DIN, IGNORE} state_t;
  typedef enum logic [2:0] {OP_NONE, OP_READ, OP_FAST, OP_PROG, OP_ERASE} op_t;
  typedef enum logic [1:0] {SRC_MEM, SRC_JEDEC, SRC_STATUS} src_t;

  state_t            state_reg;
  op_t               op_reg;
  src_t              src_reg;
  logic [2:0]        sck_sync_reg, cs_sync_reg;
  logic [1:0]        mosi_sync_reg;
  logic [2:0]        bit_pos_reg, byte_cnt_reg;
  logic [6:0]        shift_in_reg;
  logic [22:0]       addr_shift_reg;
  logic [7:0]        shift_out_reg, next_byte_reg;
  logic [1:0]        jedec_idx_reg;
  logic              first_load_reg, rd_pending_reg;
  logic              miso_reg, oe_reg, rd_en_reg, wr_en_reg, erase_req_reg;
  logic [7:0]        wr_data_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic              wip_reg, wel_reg;

  logic        sck_rise, sck_fall, cs_rise, cs_fall, mosi_bit, byte_done;
  logic [7:0]  byte_in, status_byte, load_byte;
  logic [23:0] addr_in;

  assign sck_rise    = sck_sync_reg[1] & ~sck_sync_reg[2];
  assign sck_fall    = ~sck_sync_reg[1] & sck_sync_reg[2];
  assign cs_rise     = cs_sync_reg[1] & ~cs_sync_reg[2];
  assign cs_fall     = ~cs_sync_reg[1] & cs_sync_reg[2];
  assign mosi_bit    = mosi_sync_reg[1];
  assign byte_done   = (bit_pos_reg == 3'd7);
  assign byte_in     = {shift_in_reg, mosi_bit};
  assign addr_in     = {addr_shift_reg, mosi_bit};
  assign status_byte = {6'b0, wel_reg, wip_reg};

  // Byte loaded into the output shifter at each byte boundary of DOUT.
  always_comb begin
    load_byte = status_byte;
    case (src_reg)
      SRC_MEM:   load_byte = next_byte_reg;
      SRC_JEDEC: begin
        case (jedec_idx_reg)
          2'd0:    load_byte = JEDEC_ID[23:16];
          2'd1:    load_byte = JEDEC_ID[15:8];
          2'd2:    load_byte = JEDEC_ID[7:0];
          default: load_byte = 8'h00;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_48mhz) begin
    if (reset) begin
      state_reg <= IDLE;       op_reg <= OP_NONE;        src_reg <= SRC_MEM;
      sck_sync_reg <= 3'b000;  cs_sync_reg <= 3'b111;    mosi_sync_reg <= 2'b00;
      bit_pos_reg <= '0;       byte_cnt_reg <= '0;       shift_in_reg <= '0;
      addr_shift_reg <= '0;    shift_out_reg <= '0;      next_byte_reg <= '0;
      jedec_idx_reg <= '0;     first_load_reg <= 1'b0;   rd_pending_reg <= 1'b0;
      miso_reg <= 1'b0;        oe_reg <= 1'b0;           rd_en_reg <= 1'b0;
      wr_en_reg <= 1'b0;       erase_req_reg <= 1'b0;    wr_data_reg <= '0;
      addr_reg <= '0;          wip_reg <= 1'b0;          wel_reg <= 1'b0;
    end else begin
      sck_sync_reg   <= {sck_sync_reg[1:0], spi_sck};
      cs_sync_reg    <= {cs_sync_reg[1:0], spi_cs};
      mosi_sync_reg  <= {mosi_sync_reg[0], spi_mosi};
      rd_en_reg      <= 1'b0;
      wr_en_reg      <= 1'b0;
      erase_req_reg  <= 1'b0;
      rd_pending_reg <= rd_en_reg;
      if (mem.mem_erase_done && wip_reg) begin
        wip_reg <= 1'b0;
        wel_reg <= 1'b0;
      end

      if (cs_rise) begin
        state_reg <= IDLE;  oe_reg <= 1'b0;  miso_reg <= 1'b0;
        bit_pos_reg <= '0;  byte_cnt_reg <= '0;
        first_load_reg <= 1'b0;  rd_pending_reg <= 1'b0;
`ifdef SPI_FLASH_RESP_PROGRAM_EN
        if (op_reg == OP_PROG) wel_reg <= 1'b0;
        // Erase only fires on exactly opcode + 24 address bits.
        if (op_reg == OP_ERASE && byte_cnt_reg == 3'd4 && bit_pos_reg == 3'd0) begin
          erase_req_reg <= 1'b1;
          wip_reg       <= 1'b1;
          addr_reg      <= {addr_reg[ADDR_W-1:12], 12'h000};
        end
`endif
      end else if (cs_fall) begin
        state_reg <= CMD;   oe_reg <= 1'b1;  miso_reg <= 1'b0;
        bit_pos_reg <= '0;  byte_cnt_reg <= '0;  op_reg <= OP_NONE;
        first_load_reg <= 1'b0;  rd_pending_reg <= 1'b0;
      end else if (state_reg != IDLE) begin
        if (sck_rise) begin
          bit_pos_reg  <= bit_pos_reg + 3'd1;
          shift_in_reg <= byte_in[6:0];
          if (byte_done && byte_cnt_reg != 3'd7) byte_cnt_reg <= byte_cnt_reg + 3'd1;
          case (state_reg)
            CMD: if (byte_done) begin
              state_reg <= IGNORE;
              miso_reg  <= 1'b0;
              if (byte_in == 8'h05) begin
                src_reg <= SRC_STATUS;  shift_out_reg <= status_byte;
                miso_reg <= status_byte[7];  state_reg <= DOUT;
              end else if (!wip_reg) begin
                case (byte_in)
                  8'h03: begin op_reg <= OP_READ; state_reg <= ADDR; end
                  8'h0B: begin op_reg <= OP_FAST; state_reg <= ADDR; end
                  8'h9F: begin
                    src_reg <= SRC_JEDEC;  shift_out_reg <= JEDEC_ID[23:16];
                    miso_reg <= JEDEC_ID[23];  jedec_idx_reg <= 2'd1;  state_reg <= DOUT;
                  end
`ifdef SPI_FLASH_RESP_PROGRAM_EN
                  8'h06: wel_reg <= 1'b1;
                  8'h04: wel_reg <= 1'b0;
                  8'h02: if (wel_reg) begin op_reg <= OP_PROG;  state_reg <= ADDR; end
                  8'h20: if (wel_reg) begin op_reg <= OP_ERASE; state_reg <= ADDR; end
`endif
                  default: ;
                endcase
              end
            end
            ADDR: begin
              addr_shift_reg <= addr_in[22:0];
              if (byte_done && byte_cnt_reg == 3'd3) begin
                addr_reg <= addr_in[ADDR_W-1:0];
                src_reg  <= SRC_MEM;
                case (op_reg)
                  OP_READ: begin rd_en_reg <= 1'b1; first_load_reg <= 1'b1; state_reg <= DOUT; end
                  OP_FAST: state_reg <= DUMMY;
                  OP_PROG: state_reg <= DIN;
                  default: state_reg <= IGNORE;
                endcase
              end
            end
            DUMMY: if (byte_done) begin
              rd_en_reg <= 1'b1;  first_load_reg <= 1'b1;  state_reg <= DOUT;
            end
            DOUT: if (byte_done) begin
              shift_out_reg <= load_byte;
              if (src_reg == SRC_JEDEC && jedec_idx_reg != 2'd3) jedec_idx_reg <= jedec_idx_reg + 2'd1;
            end
            DIN: if (byte_done) begin
              wr_en_reg <= 1'b1;  wr_data_reg <= byte_in;
            end
            default: ;
          endcase
        end else if (sck_fall && state_reg == DOUT) begin
          miso_reg <= shift_out_reg[3'd7 - bit_pos_reg];
          // Prefetch the following byte while bit 6 goes out.
          if (src_reg == SRC_MEM && bit_pos_reg == 3'd1) begin
            rd_en_reg <= 1'b1;
            addr_reg  <= addr_reg + ADDR_W'(1);
          end
        end
        if (rd_pending_reg && state_reg == DOUT) begin
          if (first_load_reg) begin
            shift_out_reg  <= mem.mem_rd_data;
            miso_reg       <= mem.mem_rd_data[7];
            first_load_reg <= 1'b0;
          end else begin
            next_byte_reg <= mem.mem_rd_data;
          end
        end
        if (wr_en_reg) addr_reg[7:0] <= addr_reg[7:0] + 8'd1;
      end
    end
  end

  assign spi_miso          = miso_reg;
  assign spi_miso_oe       = oe_reg;
  assign mem.mem_addr      = addr_reg;
  assign mem.mem_rd_en     = rd_en_reg;
  assign mem.mem_wr_en     = wr_en_reg;
  assign mem.mem_wr_data   = wr_data_reg;
  assign mem.mem_erase_req = erase_req_reg;
endmodule

// File: tb/tb_spi_flash_responder.sv
// Scoreboard bench for spi_flash_responder: stimulus queues expected MISO bytes, writes and erases;
// monitors pop and compare as the DUT produces them.
`timescale 1ns/1ps
module tb_spi_flash_responder;
  localparam int HALF = 200;

  logic clk_48mhz = 1'b0;
  logic reset     = 1'b1;
  logic spi_sck   = 1'b0;
  logic spi_cs    = 1'b1;
  logic spi_mosi  = 1'b0;
  logic spi_miso, spi_miso_oe;

  spi_flash_responder_if #(.ADDR_W(24)) mem_if ();

  spi_flash_responder #(.ADDR_W(24), .JEDEC_ID(24'hEF4016)) dut (
    .clk_48mhz   (clk_48mhz),
    .reset       (reset),
    .spi_sck     (spi_sck),
    .spi_cs      (spi_cs),
    .spi_mosi    (spi_mosi),
    .spi_miso    (spi_miso),
    .spi_miso_oe (spi_miso_oe),
    .mem         (mem_if)
  );

  always #10.4 clk_48mhz = ~clk_48mhz;

  typedef struct {
    string      name;
    logic [7:0] val;
    bit         care;
  } exp_t;

  exp_t        miso_q[$];
  logic [31:0] wr_q[$];
  logic [23:0] erase_q[$];
  int          total = 0;
  int          bad   = 0;
  int          rd_total = 0, rd_hi = 0, rd_lo = 0;
  bit [7:0]    mem_model [int];
  logic [7:0]  tx_buf [0:7];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Backing store: registered read, one cycle latency.
  initial mem_if.mem_erase_done = 1'b0;
  always @(posedge clk_48mhz) begin
    if (mem_if.mem_rd_en) mem_if.mem_rd_data <= mem_model[int'(mem_if.mem_addr)];
    if (mem_if.mem_wr_en) mem_model[int'(mem_if.mem_addr)] = mem_if.mem_wr_data;
  end

  // Memory-side monitor.
  always @(negedge clk_48mhz) begin
    if (mem_if.mem_rd_en) begin
      rd_total++;
      if (mem_if.mem_addr == 24'hFFFFFF) rd_hi++;
      if (mem_if.mem_addr == 24'h000000) rd_lo++;
    end
    if (mem_if.mem_wr_en) begin
      if (wr_q.size() == 0) check("unexpected_write", {mem_if.mem_addr, mem_if.mem_wr_data}, 32'hxxxxxxxx);
      else check("write", {mem_if.mem_addr, mem_if.mem_wr_data}, wr_q.pop_front());
    end
    if (mem_if.mem_erase_req) begin
      if (erase_q.size() == 0) check("unexpected_erase", {8'h00, mem_if.mem_addr}, 32'hxxxxxxxx);
      else check("erase_addr", {8'h00, mem_if.mem_addr}, {8'h00, erase_q.pop_front()});
    end
  end

  // MISO monitor: full bytes counted from CS fall; trailing partial bits dropped.
  int         nb = 0;
  logic [7:0] rx = 8'h00;
  always @(negedge spi_cs or posedge spi_sck) begin
    if (!spi_sck) begin
      nb = 0;
    end else if (!spi_cs) begin
      rx = {rx[6:0], spi_miso};
      nb++;
      if (nb == 8) begin
        exp_t e;
        nb = 0;
        if (miso_q.size() == 0) check("unexpected_miso_byte", {24'h0, rx}, 32'hxxxxxxxx);
        else begin
          e = miso_q.pop_front();
          if (e.care) check(e.name, {24'h0, rx}, {24'h0, e.val});
        end
      end
    end
  end

  task automatic exp_byte(input string name, input logic [7:0] v, input bit care);
    exp_t e;
    e.name = name; e.val = v; e.care = care;
    miso_q.push_back(e);
  endtask

  task automatic exp_skip(input int n);
    for (int i = 0; i < n; i++) exp_byte("skip", 8'h00, 1'b0);
  endtask

  task automatic set_tx(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    tx_buf[0] = b0; tx_buf[1] = b1; tx_buf[2] = b2; tx_buf[3] = b3;
    tx_buf[4] = b4; tx_buf[5] = b5; tx_buf[6] = b6; tx_buf[7] = b7;
  endtask

  task automatic spi_bit(input logic b);
    spi_mosi = b;
    #HALF spi_sck = 1'b1;
    #HALF spi_sck = 1'b0;
  endtask

  task automatic spi_txn(input string name, input int nbits);
    logic [7:0] cur;
    spi_cs = 1'b0;
    #HALF check({name, "_oe_cs_low"}, {31'h0, spi_miso_oe}, 32'd1);
    for (int i = 0; i < nbits; i++) begin
      cur = tx_buf[i / 8];
      spi_bit(cur[7 - (i % 8)]);
    end
    #HALF spi_cs = 1'b1;
    #(4 * HALF) check({name, "_oe_cs_high"}, {31'h0, spi_miso_oe}, 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_miso"},      {31'h0, spi_miso},              32'd0);
    check({tag, "_miso_oe"},   {31'h0, spi_miso_oe},           32'd0);
    check({tag, "_rd_en"},     {31'h0, mem_if.mem_rd_en},      32'd0);
    check({tag, "_wr_en"},     {31'h0, mem_if.mem_wr_en},      32'd0);
    check({tag, "_erase_req"}, {31'h0, mem_if.mem_erase_req},  32'd0);
    check({tag, "_mem_addr"},  {8'h0, mem_if.mem_addr},        32'd0);
    check({tag, "_wr_data"},   {24'h0, mem_if.mem_wr_data},    32'd0);
  endtask

  initial begin
    int hi0, lo0, tot0;
    repeat (5) @(posedge clk_48mhz);
    @(negedge clk_48mhz);
    check_reset_outputs("reset");
    reset = 1'b0;
    repeat (5) @(posedge clk_48mhz);

    // JEDEC ID then zero fill.
    set_tx(8'h9F, 0, 0, 0, 0, 0, 0, 0);
    exp_skip(1);
    exp_byte("jedec_b0", 8'hEF, 1); exp_byte("jedec_b1", 8'h40, 1);
    exp_byte("jedec_b2", 8'h16, 1); exp_byte("jedec_b3", 8'h00, 1);
    spi_txn("jedec", 40);

    // READ across the top of the address space.
    mem_model[24'hFFFFFF] = 8'hA5; mem_model[0] = 8'h3C; mem_model[1] = 8'h77;
    hi0 = rd_hi; lo0 = rd_lo;
    set_tx(8'h03, 8'hFF, 8'hFF, 8'hFF, 0, 0, 0, 0);
    exp_skip(4);
    exp_byte("read_ffffff", 8'hA5, 1); exp_byte("read_wrap_0", 8'h3C, 1);
    spi_txn("read", 48);
    check("read_rd_en_at_ffffff", rd_hi - hi0, 32'd1);
    check("read_rd_en_at_0", rd_lo - lo0, 32'd1);

    // FAST_READ with a dummy byte of all ones.
    mem_model[24'h10] = 8'h5A; mem_model[24'h11] = 8'hC3;
    set_tx(8'h0B, 8'h00, 8'h00, 8'h10, 8'hFF, 8'hFF, 8'hFF, 0);
    exp_skip(5);
    exp_byte("fast_read_10", 8'h5A, 1); exp_byte("fast_read_11", 8'hC3, 1);
    spi_txn("fast", 56);

    // Status register, repeated.
    set_tx(8'h05, 0, 0, 0, 0, 0, 0, 0);
    exp_skip(1);
    exp_byte("status_0", 8'h00, 1); exp_byte("status_1", 8'h00, 1);
    spi_txn("status", 24);

    // Unknown opcode holds MISO low.
    set_tx(8'h77, 8'hFF, 0, 0, 0, 0, 0, 0);
    exp_skip(1);
    exp_byte("unknown_op", 8'h00, 1);
    spi_txn("unknown", 16);

    // Page program aborted after 12 address bits: no write.
    set_tx(8'h02, 8'h00, 8'h01, 0, 0, 0, 0, 0);
    exp_skip(2);
    spi_txn("abort", 20);

`ifdef SPI_FLASH_RESP_PROGRAM_EN
    set_tx(8'h06, 0, 0, 0, 0, 0, 0, 0);
    exp_skip(1);
    spi_txn("wren", 8);
    set_tx(8'h05, 0, 0, 0, 0, 0, 0, 0);
    exp_skip(1); exp_byte("status_wel", 8'h02, 1);
    spi_txn("status_wel", 16);

    set_tx(8'h02, 8'h00, 8'h00, 8'hFE, 8'h11, 8'h22, 8'h33, 0);
    exp_skip(7);
    wr_q.push_back({24'h0000FE, 8'h11});
    wr_q.push_back({24'h0000FF, 8'h22});
    wr_q.push_back({24'h000000, 8'h33});
    spi_txn("program", 56);
    set_tx(8'h05, 0, 0, 0, 0, 0, 0, 0);
    exp_skip(1); exp_byte("status_after_prog", 8'h00, 1);
    spi_txn("status_after_prog", 16);

    set_tx(8'h06, 0, 0, 0, 0, 0, 0, 0);
    exp_skip(1);
    spi_txn("wren2", 8);
    set_tx(8'h20, 8'h00, 8'h12, 8'h34, 0, 0, 0, 0);
    exp_skip(4);
    erase_q.push_back(24'h001000);
    spi_txn("erase", 32);
    set_tx(8'h05, 0, 0, 0, 0, 0, 0, 0);
    exp_skip(1); exp_byte("status_busy_0", 8'h03, 1); exp_byte("status_busy_1", 8'h03, 1);
    spi_txn("status_busy", 24);

    tot0 = rd_total;
    set_tx(8'h03, 8'h00, 8'h00, 8'h00, 8'h00, 0, 0, 0);
    exp_skip(4); exp_byte("read_while_busy", 8'h00, 1);
    spi_txn("read_busy", 40);
    check("read_busy_no_rd_en", rd_total - tot0, 32'd0);

    @(negedge clk_48mhz) mem_if.mem_erase_done = 1'b1;
    @(negedge clk_48mhz) mem_if.mem_erase_done = 1'b0;
    set_tx(8'h05, 0, 0, 0, 0, 0, 0, 0);
    exp_skip(1); exp_byte("status_erase_done", 8'h00, 1);
    spi_txn("status_done", 16);
`else
    // Without program support WREN is unknown and WEL stays 0.
    set_tx(8'h06, 0, 0, 0, 0, 0, 0, 0);
    exp_skip(1);
    spi_txn("wren", 8);
    set_tx(8'h05, 0, 0, 0, 0, 0, 0, 0);
    exp_skip(1); exp_byte("status_no_wel", 8'h00, 1);
    spi_txn("status_no_wel", 16);
    set_tx(8'h02, 8'h00, 8'h00, 8'hFE, 8'h11, 0, 0, 0);
    exp_skip(4); exp_byte("program_ignored", 8'h00, 1);
    spi_txn("program_off", 40);
`endif

    // Reset asserted in the middle of a JEDEC DOUT byte.
    exp_skip(1);
    spi_cs = 1'b0;
    #HALF;
    tx_buf[0] = 8'h9F;
    for (int i = 0; i < 8; i++) spi_bit(tx_buf[0][7 - i]);
    for (int i = 0; i < 4; i++) spi_bit(1'b0);
    @(negedge clk_48mhz) reset = 1'b1;
    @(negedge clk_48mhz);
    check_reset_outputs("mid_dout_reset");
    spi_cs = 1'b1;
    repeat (5) @(negedge clk_48mhz);
    reset = 1'b0;
    #(4 * HALF);

    set_tx(8'h9F, 0, 0, 0, 0, 0, 0, 0);
    exp_skip(1);
    exp_byte("jedec_again_b0", 8'hEF, 1); exp_byte("jedec_again_b1", 8'h40, 1);
    exp_byte("jedec_again_b2", 8'h16, 1);
    spi_txn("jedec_again", 32);

    repeat (20) @(posedge clk_48mhz);
    check("miso_queue_drained", miso_q.size(), 32'd0);
    check("write_queue_drained", wr_q.size(), 32'd0);
    check("erase_queue_drained", erase_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/spi_flash_responder.md
# spi_flash_responder

SPI target that emulates a serial NOR flash for the bootloader's SPI initiator. Sits between the four SPI pins (SCK, CS, MOSI, MISO) and a byte-wide memory port, all in the clk_48mhz domain. It decodes the flash command subset the bootloader issues, serves reads from the memory port, and, when compiled in, performs program and erase. Used for board-level loopback and hardware-in-the-loop verification of the bootloader.

## Interface
- ADDR_W, 24: memory address width; SPI address bits above ADDR_W are ignored.
- JEDEC_ID, 24'hEF4016: manufacturer/type/capacity bytes returned by 0x9F, MSB byte first.
- clk_48mhz  in  1  system clock.
- reset  in  1  synchronous, active-high.
- spi_sck  in  1  SPI clock, mode 0, asynchronous to clk_48mhz, at most 4 MHz.
- spi_cs  in  1  chip select, active-low, asynchronous.
- spi_mosi  in  1  serial data in, MSB first.
- spi_miso  out  1  serial data out, MSB first.
- spi_miso_oe  out  1  MISO drive enable; pad is high-Z when 0.
- mem_addr  out  ADDR_W  byte address for read, write or erase.
- mem_rd_en  out  1  read strobe; mem_rd_data is valid exactly 1 cycle later.
- mem_rd_data  in  8  read data.
- mem_wr_en  out  1  single-cycle byte write strobe.
- mem_wr_data  out  8  write data.
- mem_erase_req  out  1  single-cycle pulse; erase 4 KiB sector at mem_addr, aligned down.
- mem_erase_done  in  1  single-cycle pulse when the erase completes.

## Operation
- Inputs pass through 2-FF synchronizers. SCK rise and fall, and CS fall and rise, are detected on the third register stage.
- States: IDLE, CMD, ADDR, DUMMY, DOUT, DIN, IGNORE.
- CS fall: IDLE→CMD, bit counter cleared, spi_miso_oe=1.
- CS rise from any state: →IDLE, spi_miso_oe=0, counters cleared. Deferred actions (erase, WEL clear) are evaluated on this edge.
- MOSI is sampled on SCK rise. MISO shifts on SCK fall.
- Command byte decode:
  - 0x03 READ: ADDR, then DOUT.
  - 0x0B FAST_READ: ADDR, then 8 DUMMY clocks, then DOUT.
  - 0x9F: DOUT of JEDEC_ID, then 0x00 repeated.
  - 0x05: DOUT of status register, repeated while CS is low.
  - 0xAB, 0xB9: accepted, no effect; →IGNORE.
  - 0x06, 0x04, 0x02, 0x20: see Configuration.
  - Any other opcode: →IGNORE (MISO held 0 until CS rise).
- Status register: bit0 = WIP, bit1 = WEL, bits 7:2 = 0.
- While WIP=1, every opcode except 0x05 is treated as unknown.
- READ address: the 24-bit address is latched after the 24th address bit. mem_rd_en pulses on the cycle after that SCK-rise detect, and the returned byte loads the output shift register.
- During DOUT the next byte is prefetched (mem_rd_en) on the SCK fall that shifts bit 6. The address increments modulo 2^ADDR_W and wraps to 0.
- Abort of a read mid-byte: no side effects.

## Timing
- Reset values: spi_miso=0, spi_miso_oe=0, mem_rd_en=0, mem_wr_en=0, mem_erase_req=0, mem_addr=0, mem_wr_data=0, WIP=0, WEL=0, state IDLE.
- spi_miso changes 3–4 clk_48mhz cycles after the SCK pin falls. It is stable at least 2 cycles before the next SCK rise at 4 MHz.
- First data bit (MSB) of DOUT is on spi_miso before the SCK fall following the last address/dummy/command bit. It is driven during the low phase preceding the first data rising edge.
- Byte boundaries count SCK rises since CS fall. Partial trailing bits are discarded.
- reset overrides everything in the same cycle, including an erase in progress. mem_erase_done arriving after reset is ignored.
- CS rise and SCK edge detected in the same cycle: CS rise wins.

## Configuration
- SPI_FLASH_RESP_PROGRAM_EN defined:
  - 0x06 sets WEL; 0x04 clears WEL.
  - 0x02 PAGE_PROGRAM with WEL=1: ADDR, then DIN. Each completed byte pulses mem_wr_en with mem_wr_data. The address increments within the 256-byte page, wrapping addr[7:0] only. WEL clears on CS rise.
  - 0x20 SECTOR_ERASE with WEL=1: exactly 32 bits at CS rise pulse mem_erase_req and set WIP=1. mem_erase_done clears WIP and WEL. Any other bit count: no erase, WEL kept.
  - 0x02 or 0x20 with WEL=0: →IGNORE.
- Undefined: 0x06, 0x04, 0x02, 0x20 are treated as unknown. WEL and WIP read as 0. mem_wr_en, mem_wr_data and mem_erase_req are tied 0.

## Test plan
- 0x9F plus 32 clocks → MISO bytes EF 40 16 00; spi_miso_oe=1 only while CS is low.
- 0x03 at address 0xFFFFFF (ADDR_W=24), memory[FFFFFF]=0xA5, memory[0]=0x3C, 16 data clocks → A5 3C; mem_rd_en pulses exactly twice for these two bytes.
- 0x0B at address 0x000010 plus dummy byte → byte at 0x10 returned after 8 dummy clocks; MOSI during the dummy byte is ignored.
- (PROGRAM_EN) 0x06; 0x02 at address 0x0000FE, bytes 11 22 33 → writes 0xFE=11, 0xFF=22, 0x00=33; 0x05 then returns 0x00.
- (PROGRAM_EN) 0x06; 0x20 at address 0x001234 → mem_erase_req with mem_addr=0x001000 at CS rise; 0x05 returns 0x03 until mem_erase_done, then 0x00; 0x03 issued while busy returns 0x00 and no mem_rd_en.
- CS raised after 12 address bits of 0x02, and reset asserted mid-DOUT → no mem_wr_en, state IDLE, all outputs at reset values, next 0x9F works.
